user_ip_apb_demux: RTL and testbench

- APB4 demultiplexer/bridge directly upstream of the user IP slots.
- Accepts transfers from the SoC peripheral crossbar and selects one of SLOT_NUM user IP slots from address bits.
- Re-issues each transfer as a fresh, registered APB setup/access pair with slot-relative address, and returns the slot's response.
- Isolates the SoC from misbehaving slots through a wait-state timeout and an out-of-range error.

---
 rtl/user_ip_apb_demux.sv | 181 ++++++++++++++++++
 tb/tb_user_ip_apb_demux.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_ip_apb_demux.sv
// rtl/user_ip_apb_demux.sv - APB4 demux to user IP slots; optional timeout via USER_IP_APB_TIMEOUT_EN
module user_ip_apb_demux #(
    parameter int SLOT_NUM = 4,
    parameter int SLOT_AW  = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [31:0]           s_paddr_i,
    input  logic                  s_psel_i,
    input  logic                  s_penable_i,
    input  logic                  s_pwrite_i,
    input  logic [31:0]           s_pwdata_i,
    input  logic [3:0]            s_pstrb_i,
    output logic [31:0]           s_prdata_o,
    output logic                  s_pready_o,
    output logic                  s_pslverr_o,
    output logic [31:0]           m_paddr_o,
    output logic                  m_pwrite_o,
    output logic [31:0]           m_pwdata_o,
    output logic [3:0]            m_pstrb_o,
    output logic [SLOT_NUM-1:0]   m_psel_o,
    output logic                  m_penable_o,
    input  logic [SLOT_NUM*32-1:0] m_prdata_i,
    input  logic [SLOT_NUM-1:0]   m_pready_i,
    input  logic [SLOT_NUM-1:0]   m_pslverr_i
);

    localparam int IDX_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [SLOT_AW-1:0] req_addr;
    logic               req_write;
    logic [31:0]        req_wdata;
    logic [3:0]         req_strb;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        rdata_q;
    logic               slverr_q;

    logic [IDX_W-1:0]   in_idx;
    logic               setup_req;
    logic               idx_bad;
    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;
    logic               unused_addr_bits;

    assign in_idx           = s_paddr_i[SLOT_AW +: IDX_W];
    assign setup_req        = s_psel_i & ~s_penable_i;
    assign idx_bad          = ({1'b0, in_idx} >= (IDX_W + 1)'(SLOT_NUM));
    assign unused_addr_bits = ^s_paddr_i;

    // Pick the selected slot's response; responses of other slots never leak through
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < SLOT_NUM; k++) begin
            if (req_idx == IDX_W'(k)) begin
                sel_ready = m_pready_i[k];
                sel_err   = m_pslverr_i[k];
                sel_rdata = m_prdata_i[32*k +: 32];
            end
        end
    end

`ifdef USER_IP_APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // The access that would bring the count to TIMEOUT is the last one allowed
    assign timeout_hit = (state == M_ACCESS) && !sel_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Saturating wait-state counter, cleared once the response is delivered
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (state == RESP) begin
            wait_cnt <= '0;
        end else if (state == M_ACCESS && !sel_ready && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (setup_req) begin
                    state_nxt = idx_bad ? RESP : M_SETUP;
                end
            end
            M_SETUP:  state_nxt = M_ACCESS;
            M_ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE and response capture at the end of the downstream access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_wdata <= '0;
            req_strb  <= '0;
            req_idx   <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
        end else begin
            if (state == IDLE && setup_req) begin
                req_addr  <= s_paddr_i[SLOT_AW-1:0];
                req_write <= s_pwrite_i;
                req_wdata <= s_pwdata_i;
                req_strb  <= s_pstrb_i;
                req_idx   <= in_idx;
                if (idx_bad) begin
                    rdata_q  <= '0;
                    slverr_q <= 1'b1;
                end
            end
            if (state == M_ACCESS) begin
                if (sel_ready) begin
                    rdata_q  <= req_write ? 32'h0 : sel_rdata;
                    slverr_q <= sel_err;
                end else if (timeout_hit) begin
                    rdata_q  <= 32'hDEAD_BEEF;
                    slverr_q <= 1'b1;
                end
            end
        end
    end

    // Outputs decoded from the state; select lines follow the async reset of the state
    always_comb begin
        m_psel_o    = '0;
        m_penable_o = (state == M_ACCESS);
        s_pready_o  = (state == RESP);
        s_prdata_o  = (state == RESP) ? rdata_q : 32'h0;
        s_pslverr_o = (state == RESP) && slverr_q;
        if (state == M_SETUP || state == M_ACCESS) begin
            for (int k = 0; k < SLOT_NUM; k++) begin
                m_psel_o[k] = (req_idx == IDX_W'(k));
            end
        end
    end

    assign m_paddr_o  = {{(32 - SLOT_AW){1'b0}}, req_addr};
    assign m_pwrite_o = req_write;
    assign m_pwdata_o = req_wdata;
    assign m_pstrb_o  = req_strb;

endmodule

// File: tb/tb_user_ip_apb_demux.sv
// tb/tb_user_ip_apb_demux.sv - randomized self-checking bench for user_ip_apb_demux
module tb_user_ip_apb_demux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_paddr;
    logic         s_psel;
    logic         s_penable;
    logic         s_pwrite;
    logic [31:0]  s_pwdata;
    logic [3:0]   s_pstrb;
    logic [31:0]  s_prdata;
    logic         s_pready;
    logic         s_pslverr;
    logic [31:0]  m_paddr;
    logic         m_pwrite;
    logic [31:0]  m_pwdata;
    logic [3:0]   m_pstrb;
    logic [3:0]   m_psel;
    logic         m_penable;
    logic [127:0] m_prdata;
    logic [3:0]   m_pready;
    logic [3:0]   m_pslverr;

    logic [31:0]  s_prdata2;
    logic         s_pready2;
    logic         s_pslverr2;
    logic [31:0]  m_paddr2;
    logic         m_pwrite2;
    logic [31:0]  m_pwdata2;
    logic [3:0]   m_pstrb2;
    logic [2:0]   m_psel2;
    logic         m_penable2;

    logic [31:0]  slot_data [4];
    logic [3:0]   err_bits;
    int           wait_cfg;
    int           acc_cnt;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n;

    always #5 clk = ~clk;

    user_ip_apb_demux #(.SLOT_NUM(4), .SLOT_AW(8), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
        .m_paddr_o(m_paddr), .m_pwrite_o(m_pwrite), .m_pwdata_o(m_pwdata),
        .m_pstrb_o(m_pstrb), .m_psel_o(m_psel), .m_penable_o(m_penable),
        .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr)
    );

    user_ip_apb_demux #(.SLOT_NUM(3), .SLOT_AW(8), .TIMEOUT(16)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_prdata_o(s_prdata2), .s_pready_o(s_pready2), .s_pslverr_o(s_pslverr2),
        .m_paddr_o(m_paddr2), .m_pwrite_o(m_pwrite2), .m_pwdata_o(m_pwdata2),
        .m_pstrb_o(m_pstrb2), .m_psel_o(m_psel2), .m_penable_o(m_penable2),
        .m_prdata_i({3{32'hA5A5_0001}}), .m_pready_i(3'b111), .m_pslverr_i(3'b000)
    );

    // Slot model: a selected slot holds pready low for wait_cfg access cycles; unselected slots always ready
    assign m_prdata  = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
    assign m_pslverr = err_bits;
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            m_pready[k] = m_psel[k] ? (acc_cnt >= wait_cfg) : 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc_cnt <= 0;
        else if (m_penable) acc_cnt <= acc_cnt + 1;
        else                acc_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_setup(input int slot, input logic [7:0] off, input logic wr,
                               input logic [31:0] wd, input logic [3:0] st, input int wt,
                               input logic [31:0] rd);
        @(negedge clk);
        wait_cfg = wt;
        for (int k = 0; k < 4; k++) slot_data[k] = $urandom;
        slot_data[slot] = rd;
        err_bits  = 4'($urandom);
        s_paddr   = (32'(slot) << 8) | 32'(off);
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_pwrite  = wr;
        s_pwdata  = wd;
        s_pstrb   = st;
    endtask

    // One full upstream transfer, checked against the expected downstream request and response
    task automatic do_xfer(input int slot, input logic [7:0] off, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input int wt,
                           input logic [31:0] rd, input bit drop, input bit tmo);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        start_setup(slot, off, wr, wd, st, wt, rd);
        @(negedge clk);
        n = 1;
        check("setup_psel",   32'(m_psel), 32'(4'b0001 << slot));
        check("setup_penable", 32'(m_penable), 32'd0);
        check("setup_paddr",  m_paddr, 32'(off));
        check("setup_pwrite", 32'(m_pwrite), 32'(wr));
        check("setup_pwdata", m_pwdata, wd);
        check("setup_pstrb",  32'(m_pstrb), 32'(st));
        check("setup_no_ready", 32'(s_pready), 32'd0);
        if (drop) s_psel = 1'b0;
        else      s_penable = 1'b1;
        while (!s_pready && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp_lat   = tmo ? 18 : 3 + wt;
        exp_rdata = tmo ? 32'hDEAD_BEEF : (wr ? 32'h0 : rd);
        exp_err   = tmo ? 1'b1 : err_bits[slot];
        check("latency",   32'(n), 32'(exp_lat));
        check("resp_rdata", s_prdata, exp_rdata);
        check("resp_err",  32'(s_pslverr), 32'(exp_err));
        check("resp_psel", 32'(m_psel), 32'd0);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        @(negedge clk);
        check("after_ready", 32'(s_pready), 32'd0);
        check("after_rdata", s_prdata, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        s_paddr   = '0;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pwrite  = 1'b0;
        s_pwdata  = '0;
        s_pstrb   = '0;
        wait_cfg  = 0;
        err_bits  = '0;
        for (int k = 0; k < 4; k++) slot_data[k] = '0;
        #12;
        check("rst_psel",    32'(m_psel), 32'd0);
        check("rst_penable", 32'(m_penable), 32'd0);
        check("rst_paddr",   m_paddr, 32'd0);
        check("rst_pready",  32'(s_pready), 32'd0);
        check("rst_prdata",  s_prdata, 32'd0);
        check("rst_pslverr", 32'(s_pslverr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ID read of slot 0 and write to slot 2
        do_xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, 0, 32'h0000_00FF, 1'b0, 1'b0);
        do_xfer(2, 8'h04, 1'b1, 32'h1234_5678, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        // wait states on slot 1
        do_xfer(1, 8'h10, 1'b0, 32'h0, 4'h0, 5, 32'h5555_AAAA, 1'b0, 1'b0);
        // upstream select dropped mid-transfer
        do_xfer(3, 8'h08, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);

        // randomized transfers
        for (int i = 0; i < 24; i++) begin
            do_xfer($urandom_range(0, 3), 8'($urandom), 1'($urandom), $urandom,
                    4'($urandom), $urandom_range(0, 4), $urandom, 1'b0, 1'b0);
        end

        // slot 3 never ready
`ifdef USER_IP_APB_TIMEOUT_EN
        do_xfer(3, 8'h20, 1'b0, 32'h0, 4'h0, 100000, 32'h1111_2222, 1'b0, 1'b1);
`else
        start_setup(3, 8'h20, 1'b0, 32'h0, 4'h0, 100000, 32'h1111_2222);
        @(negedge clk);
        s_penable = 1'b1;
        for (int i = 1; i < 100; i++) @(negedge clk);
        check("hang_pready",  32'(s_pready), 32'd0);
        check("hang_psel",    32'(m_psel), 32'h8);
        check("hang_penable", 32'(m_penable), 32'd1);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // out-of-range slot on the three-slot instance
        start_setup(3, 8'h00, 1'b0, 32'h0, 4'h0, 0, 32'h7777_7777);
        @(negedge clk);
        check("oor_pready",  32'(s_pready2), 32'd1);
        check("oor_pslverr", 32'(s_pslverr2), 32'd1);
        check("oor_prdata",  s_prdata2, 32'd0);
        check("oor_psel",    32'(m_psel2), 32'd0);
        s_penable = 1'b1;
        @(negedge clk);
        check("oor_psel_late", 32'(m_psel2), 32'd0);
        check("oor_pulse_end", 32'(s_pready2), 32'd0);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        repeat (4) @(negedge clk);

        // reset in the middle of a slot 1 access
        start_setup(1, 8'h00, 1'b0, 32'h0, 4'h0, 10, 32'h3333_4444);
        @(negedge clk);
        s_penable = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_penable", 32'(m_penable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_psel",    32'(m_psel), 32'd0);
        check("async_rst_penable", 32'(m_penable), 32'd0);
        check("async_rst_pready",  32'(s_pready), 32'd0);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, 0, 32'h0000_00FF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
